menu_select_controller: RTL and testbench



---
 rtl/menu_select_controller.sv | 201 ++++++++++++++++++++
 tb/tb_menu_select_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_select_controller.sv
// menu_select_controller
//   Main-menu sequencer. Turns debounced button levels into the highlighted
//   option index (sel_index, drives metadata[28:26]), launches the chosen mode
//   and parks until that mode signals it has finished.
//
//   Handshake: start_pulse is a one-cycle strobe; start_mode is valid while
//   start_pulse=1 and otherwise holds the last launched value. return_menu is
//   a one-cycle pulse that is only honoured in ACTIVE.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   btn_up/down/left/right/select  debounced button levels (clock domain)
//   return_menu  one-cycle pulse: launched mode finished
//   sel_index    highlighted option 0..4
//   menu_active  1 while the menu screen is shown
//   start_pulse  one-cycle launch strobe
//   start_mode   option being launched / last launched
//   state        0=MENU, 1=LAUNCH, 2=ACTIVE
module menu_select_controller #(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 6250000,
  parameter int CNT_W        = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  input  logic       return_menu,
  output logic [2:0] sel_index,
  output logic       menu_active,
  output logic       start_pulse,
  output logic [2:0] start_mode,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_MENU   = 2'd0,
    S_LAUNCH = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    D_NONE  = 3'd0,
    D_UP    = 3'd1,
    D_DOWN  = 3'd2,
    D_LEFT  = 3'd3,
    D_RIGHT = 3'd4
  } dir_t;

  state_t           st;
  logic [4:0]       btn;        // {right, left, down, up, select}
  logic [4:0]       btn_prev;
  logic [4:0]       press;
  dir_t             held_dir;
  dir_t             press_dir;
  dir_t             dir_q;      // held direction seen last cycle
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] repeat_limit;
  logic             first_done; // first auto-repeat of this hold has fired
  logic             cnt_clear;
  logic             repeat_hit;

  // One navigation step in the two-column layout:
  // left column 0,1,2 ; right column 3,4.
  function automatic logic [2:0] nav(input logic [2:0] cur, input dir_t d);
    logic [2:0] nxt;
    nxt = cur;
    case (d)
      D_UP: begin
        case (cur)
          3'd0:    nxt = 3'd2;
          3'd1:    nxt = 3'd0;
          3'd2:    nxt = 3'd1;
          3'd3:    nxt = 3'd4;
          3'd4:    nxt = 3'd3;
          default: nxt = 3'd0;
        endcase
      end
      D_DOWN: begin
        case (cur)
          3'd0:    nxt = 3'd1;
          3'd1:    nxt = 3'd2;
          3'd2:    nxt = 3'd0;
          3'd3:    nxt = 3'd4;
          3'd4:    nxt = 3'd3;
          default: nxt = 3'd0;
        endcase
      end
      D_LEFT: begin
        case (cur)
          3'd3:    nxt = 3'd0;
          3'd4:    nxt = 3'd1;
          default: nxt = cur;
        endcase
      end
      D_RIGHT: begin
        case (cur)
          3'd0:    nxt = 3'd3;
          3'd1:    nxt = 3'd4;
          3'd2:    nxt = 3'd4;
          default: nxt = cur;
        endcase
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  always_comb begin
    btn   = {btn_right, btn_left, btn_down, btn_up, btn_select};
    press = btn & ~btn_prev;

    held_dir = D_NONE;
    if (btn[1])      held_dir = D_UP;
    else if (btn[2]) held_dir = D_DOWN;
    else if (btn[3]) held_dir = D_LEFT;
    else if (btn[4]) held_dir = D_RIGHT;

    press_dir = D_NONE;
    if (press[1])      press_dir = D_UP;
    else if (press[2]) press_dir = D_DOWN;
    else if (press[3]) press_dir = D_LEFT;
    else if (press[4]) press_dir = D_RIGHT;

    repeat_limit = first_done ? CNT_W'(REPEAT_RATE - 1) : CNT_W'(REPEAT_DELAY - 1);

    // Any new press, a release, or a change of held direction restarts the hold.
    cnt_clear  = (|press) || (held_dir == D_NONE) || (held_dir != dir_q);
    repeat_hit = !cnt_clear && (hold_cnt == repeat_limit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= S_MENU;
      sel_index   <= 3'd0;
      menu_active <= 1'b1;
      start_pulse <= 1'b0;
      start_mode  <= 3'd0;
      btn_prev    <= 5'b11111;  // a button held through reset must be released first
      dir_q       <= D_NONE;
      hold_cnt    <= '0;
      first_done  <= 1'b0;
    end else begin
      btn_prev    <= btn;
      dir_q       <= held_dir;
      start_pulse <= 1'b0;
      case (st)
        S_MENU: begin
          if (sel_index > 3'd4) begin
            sel_index <= 3'd0;
          end else if (press[0]) begin
            st          <= S_LAUNCH;
            start_mode  <= sel_index;
            start_pulse <= 1'b1;
            menu_active <= 1'b0;
          end else if (press_dir != D_NONE) begin
            sel_index <= nav(sel_index, press_dir);
          end else if (repeat_hit) begin
            sel_index <= nav(sel_index, held_dir);
          end

          if (cnt_clear) begin
            hold_cnt   <= '0;
            first_done <= 1'b0;
          end else if (repeat_hit) begin
            hold_cnt   <= '0;
            first_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_LAUNCH: begin
          st         <= S_ACTIVE;
          hold_cnt   <= '0;
          first_done <= 1'b0;
        end
        S_ACTIVE: begin
          hold_cnt   <= '0;
          first_done <= 1'b0;
          if (return_menu) begin
            st          <= S_MENU;
            menu_active <= 1'b1;
          end
        end
        default: begin
          st          <= S_MENU;
          menu_active <= 1'b1;
          hold_cnt    <= '0;
          first_done  <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_menu_select_controller.sv
// tb_menu_select_controller
//   Directed steps followed by a randomized phase; every cycle the DUT outputs
//   are compared with a table-driven reference model of the menu rules.
module tb_menu_select_controller;

  localparam int RD = 8;
  localparam int RR = 4;
  localparam int CW = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right, btn_select;
  logic       return_menu;
  logic [2:0] sel_index;
  logic       menu_active;
  logic       start_pulse;
  logic [2:0] start_mode;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clock = ~clock;

  menu_select_controller #(
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .CNT_W       (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_select (btn_select),
    .return_menu(return_menu),
    .sel_index  (sel_index),
    .menu_active(menu_active),
    .start_pulse(start_pulse),
    .start_mode (start_mode),
    .state      (state)
  );

  // Reference model. Buttons indexed 0=select 1=up 2=down 3=left 4=right;
  // mode 0=menu 1=launch 2=active.
  int up_t[5]    = '{2, 0, 1, 4, 3};
  int down_t[5]  = '{1, 2, 0, 4, 3};
  int left_t[5]  = '{0, 1, 2, 0, 1};
  int right_t[5] = '{3, 4, 4, 3, 4};

  int m_sel, m_mode, m_start_mode, m_pulse, m_active;
  int m_cnt, m_first, m_dir;
  int m_prev[5];

  function automatic int move(input int cur, input int d);
    case (d)
      1: return up_t[cur];
      2: return down_t[cur];
      3: return left_t[cur];
      4: return right_t[cur];
      default: return cur;
    endcase
  endfunction

  task automatic model_step();
    int b[5];
    int pr[5];
    int held, pdir, anyp, thr;
    b[0] = int'(btn_select); b[1] = int'(btn_up); b[2] = int'(btn_down);
    b[3] = int'(btn_left);   b[4] = int'(btn_right);
    if (reset) begin
      m_sel = 0; m_mode = 0; m_start_mode = 0; m_pulse = 0; m_active = 1;
      m_cnt = 0; m_first = 0; m_dir = 0;
      for (int i = 0; i < 5; i++) m_prev[i] = 1;
      return;
    end
    anyp = 0; held = 0; pdir = 0;
    for (int i = 0; i < 5; i++) begin
      pr[i] = (b[i] == 1 && m_prev[i] == 0) ? 1 : 0;
      if (pr[i] == 1) anyp = 1;
    end
    for (int i = 4; i >= 1; i--) begin
      if (b[i] == 1)  held = i;
      if (pr[i] == 1) pdir = i;
    end
    m_pulse = 0;
    if (m_mode == 0) begin
      thr = (m_first == 1) ? RR - 1 : RD - 1;
      if (pr[0] == 1) begin
        m_mode = 1; m_start_mode = m_sel; m_pulse = 1; m_active = 0;
      end else if (pdir != 0) begin
        m_sel = move(m_sel, pdir);
      end
      if (anyp == 1 || held == 0 || held != m_dir) begin
        m_cnt = 0; m_first = 0;
      end else if (m_cnt == thr) begin
        m_sel = move(m_sel, held);
        m_cnt = 0; m_first = 1;
      end else begin
        m_cnt++;
      end
    end else if (m_mode == 1) begin
      m_mode = 2; m_cnt = 0; m_first = 0;
    end else begin
      m_cnt = 0; m_first = 0;
      if (return_menu) begin
        m_mode = 0; m_active = 1;
      end
    end
    for (int i = 0; i < 5; i++) m_prev[i] = b[i];
    m_dir = held;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("model_sel",   32'(sel_index),   32'(m_sel));
    check("model_state", 32'(state),       32'(m_mode));
    check("model_menu",  32'(menu_active), 32'(m_active));
    check("model_pulse", 32'(start_pulse), 32'(m_pulse));
    check("model_smode", 32'(start_mode),  32'(m_start_mode));
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_select = v;
      1: btn_up     = v;
      2: btn_down   = v;
      3: btn_left   = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic pulse_btn(input int which);
    set_btn(which, 1'b1);
    tick();
    set_btn(which, 1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b1; return_menu = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_select = 1'b0;
    tick();
    tick();
    check("rst_sel",   32'(sel_index),   32'd0);
    check("rst_state", 32'(state),       32'd0);
    check("rst_menu",  32'(menu_active), 32'd1);
    check("rst_pulse", 32'(start_pulse), 32'd0);
    check("rst_smode", 32'(start_mode),  32'd0);
    reset = 1'b0;
    tick();

    // down presses: 1, 2, 0, each visible right after the edge that sees it
    btn_down = 1'b1; tick(); check("down_a", 32'(sel_index), 32'd1);
    btn_down = 1'b0; tick();
    btn_down = 1'b1; tick(); check("down_b", 32'(sel_index), 32'd2);
    btn_down = 1'b0; tick();
    btn_down = 1'b1; tick(); check("down_c", 32'(sel_index), 32'd0);
    btn_down = 1'b0; tick();

    // column moves from 2
    pulse_btn(2); pulse_btn(2);
    check("to_two", 32'(sel_index), 32'd2);
    pulse_btn(4); check("right_2", 32'(sel_index), 32'd4);
    pulse_btn(1); check("up_4",    32'(sel_index), 32'd3);
    pulse_btn(3); check("left_3",  32'(sel_index), 32'd0);
    pulse_btn(3); check("left_0",  32'(sel_index), 32'd0);

    // auto-repeat: steps at press, +8, +12, +16
    btn_down = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_sel", 32'(sel_index),
            (i < 8) ? 32'd1 : (i < 12) ? 32'd2 : (i < 16) ? 32'd0 : 32'd1);
    end
    btn_down = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("release_sel", 32'(sel_index), 32'd1);
    end

    // reach 3, then select + up together
    pulse_btn(4); pulse_btn(1);
    check("at_three", 32'(sel_index), 32'd3);
    btn_select = 1'b1; btn_up = 1'b1;
    tick();
    check("launch_state", 32'(state),       32'd1);
    check("launch_pulse", 32'(start_pulse), 32'd1);
    check("launch_mode",  32'(start_mode),  32'd3);
    check("launch_sel",   32'(sel_index),   32'd3);
    check("launch_menu",  32'(menu_active), 32'd0);
    btn_select = 1'b0; btn_up = 1'b0;
    tick();
    check("active_state", 32'(state),       32'd2);
    check("active_pulse", 32'(start_pulse), 32'd0);
    pulse_btn(2); pulse_btn(4); pulse_btn(1);
    check("active_sel", 32'(sel_index), 32'd3);

    // return with down held: no move until a fresh press
    btn_down = 1'b1; tick();
    return_menu = 1'b1; tick();
    check("ret_state", 32'(state),       32'd0);
    check("ret_menu",  32'(menu_active), 32'd1);
    check("ret_sel",   32'(sel_index),   32'd3);
    return_menu = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ret_hold", 32'(sel_index), 32'd3);
    end
    btn_down = 1'b0; tick();
    btn_down = 1'b1; tick();
    check("ret_repress", 32'(sel_index), 32'd4);
    btn_down = 1'b0; tick();

    // reset during LAUNCH
    btn_select = 1'b1; tick();
    check("pre_rst_state", 32'(state), 32'd1);
    btn_select = 1'b0; reset = 1'b1; btn_up = 1'b1;
    tick();
    check("mid_rst_pulse", 32'(start_pulse), 32'd0);
    check("mid_rst_state", 32'(state),       32'd0);
    check("mid_rst_sel",   32'(sel_index),   32'd0);
    check("mid_rst_menu",  32'(menu_active), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_thru_rst", 32'(sel_index), 32'd0);
    end
    btn_up = 1'b0; tick();
    btn_up = 1'b1; tick();
    check("rst_repress", 32'(sel_index), 32'd2);
    btn_up = 1'b0; tick();

    // randomized phase, checked every cycle against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int w;
        w = int'($urandom_range(0, 4));
        case (w)
          0: btn_select = ~btn_select;
          1: btn_up     = ~btn_up;
          2: btn_down   = ~btn_down;
          3: btn_left   = ~btn_left;
          default: btn_right = ~btn_right;
        endcase
      end
      return_menu = ($urandom_range(0, 15) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
